// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters,
// data-first with a fetch anti-starvation streak limit and an access timeout. rev 1.0
`default_nettype none

module mem_port_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ready,
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  output logic                    dm_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    err
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int TOUT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [STREAK_W-1:0] streak, streak_next;
  logic [TOUT_W-1:0]   tout_cnt, tout_next;
  logic                busy, timed_out, done, grant_dm, grant_if;

  always_comb begin
    busy        = (state != IDLE);
    // Ack takes precedence over a timeout landing in the same cycle.
    timed_out   = busy && !mem_ack && (tout_cnt == TOUT_W'(TIMEOUT - 1));
    done        = busy && (mem_ack || timed_out);
    grant_dm    = (state == IDLE) && dm_req &&
                  (!if_req || (streak < STREAK_W'(MAX_DATA_STREAK)));
    grant_if    = (state == IDLE) && !grant_dm && if_req;

    state_next  = state;
    streak_next = streak;
    tout_next   = tout_cnt;

    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_next  = DM_BUSY;
          tout_next   = '0;
          if (!if_req)
            streak_next = '0;
          else if (streak != STREAK_W'(MAX_DATA_STREAK))
            streak_next = streak + STREAK_W'(1);
        end else if (grant_if) begin
          state_next  = IF_BUSY;
          tout_next   = '0;
          streak_next = '0;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (done) begin
          state_next = IDLE;
          tout_next  = '0;
        end else begin
          tout_next  = tout_cnt + TOUT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      tout_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state    <= state_next;
      streak   <= streak_next;
      tout_cnt <= tout_next;
      if (grant_dm) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
      end else if (grant_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
      end
    end
  end

  assign mem_req  = busy;
  assign if_ready = (state == IF_BUSY) && done;
  assign dm_ready = (state == DM_BUSY) && done;
  assign err      = timed_out;
  assign if_rdata = ((state == IF_BUSY) && mem_ack) ? mem_rdata : '0;
  assign dm_rdata = ((state == DM_BUSY) && mem_ack) ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with grant/response scoreboards and a
// latency-programmable memory model. rev 1.0
`default_nettype none

module tb_mem_port_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXS = 4;
  localparam int TOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [BW-1:0] dm_be;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          if_ready, dm_ready;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  typedef struct {
    bit            dm;
    logic [DW-1:0] data;
    bit            err;
    int            busy;
  } resp_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    bit            chk_wdata;
  } grant_t;

  resp_t  resp_q[$];
  grant_t grant_q[$];
  int     checks = 0;
  int     passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    checks++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic push_g(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input bit chkw);
    grant_t g;
    g.we = we; g.addr = a; g.wdata = wd; g.be = be; g.chk_wdata = chkw;
    grant_q.push_back(g);
  endtask

  task automatic push_r(input bit dm, input logic [DW-1:0] d, input bit e, input int b);
    resp_t r;
    r.dm = dm; r.data = d; r.err = e; r.busy = b;
    resp_q.push_back(r);
  endtask

  // Memory model: acks on busy-cycle index lat (0 = first cycle); lat < 0 never acks.
  int lat = 0;
  int wcnt = 0;
  bit stray_ack = 1'b0;

  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      mem_ack   = (lat >= 0) && (wcnt == lat);
      mem_rdata = mem_ack ? model_rdata(mem_addr) : 32'h5A5A5A5A;
      wcnt++;
    end else begin
      wcnt      = 0;
      mem_ack   = stray_ack;
      mem_rdata = 32'hBAD0BAD0;
    end
  end

  grant_t cur;
  bit     have_cur = 1'b0;
  bit     stable_bad = 1'b0;
  bit     prev_req = 1'b0;
  int     busy_cnt = 0;
  resp_t  r;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && !prev_req) begin
        busy_cnt   = 1;
        stable_bad = 1'b0;
        if (grant_q.size() == 0) begin
          fail_now("unexpected_grant");
          have_cur = 1'b0;
        end else begin
          cur      = grant_q.pop_front();
          have_cur = 1'b1;
          check("grant_we",   {31'd0, mem_we}, {31'd0, cur.we});
          check("grant_addr", mem_addr, cur.addr);
          check("grant_be",   {28'd0, mem_be}, {28'd0, cur.be});
          if (cur.chk_wdata) check("grant_wdata", mem_wdata, cur.wdata);
        end
      end else if (mem_req) begin
        busy_cnt++;
        if (have_cur && (mem_we !== cur.we || mem_addr !== cur.addr || mem_be !== cur.be ||
                         (cur.chk_wdata && mem_wdata !== cur.wdata)))
          stable_bad = 1'b1;
      end else if (prev_req && have_cur) begin
        check("req_fields_stable", {31'd0, stable_bad}, 32'd0);
        have_cur = 1'b0;
      end

      if (if_ready && dm_ready) fail_now("both_ready");
      if (if_ready || dm_ready) begin
        if (resp_q.size() == 0) begin
          fail_now("unexpected_ready");
        end else begin
          r = resp_q.pop_front();
          check("ready_owner", {31'd0, dm_ready}, {31'd0, r.dm});
          check("rdata", r.dm ? dm_rdata : if_rdata, r.data);
          check("err", {31'd0, err}, {31'd0, r.err});
          check("busy_cycles", busy_cnt, r.busy);
        end
      end else if (err) begin
        fail_now("err_without_ready");
      end
    end
    prev_req = mem_req;
  end

  task automatic wait_ready(input bit dm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dm ? dm_ready : if_ready) && n < 200);
    if (n >= 200) fail_now(dm ? "dm_ready_timeout" : "if_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    if_req  = 1'b1;
    if_addr = a;
    wait_ready(1'b0);
    if_req  = 1'b0;
  endtask

  task automatic data(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [BW-1:0] be);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be;
    wait_ready(1'b1);
    dm_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be",    {28'd0, mem_be}, 32'd0);
    check("rst_if_ready",  {31'd0, if_ready}, 32'd0);
    check("rst_dm_ready",  {31'd0, dm_ready}, 32'd0);
    check("rst_err",       {31'd0, err}, 32'd0);
    check("rst_if_rdata",  if_rdata, 32'd0);
    check("rst_dm_rdata",  dm_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single load, ack on the 4th busy cycle
    lat = 3;
    push_g(1'b0, 32'h100, '0, 4'hF, 1'b0);
    push_r(1'b1, 32'hDEADBEEF, 1'b0, 4);
    data(1'b0, 32'h100, '0, 4'hF);

    // Store with partial byte enables
    lat = 2;
    push_g(1'b1, 32'h200, 32'h1234ABCD, 4'h3, 1'b1);
    push_r(1'b1, model_rdata(32'h200), 1'b0, 3);
    data(1'b1, 32'h200, 32'h1234ABCD, 4'h3);

    // Contention: data first, then fetch
    lat = 0;
    push_g(1'b0, 32'h300, '0, 4'hF, 1'b0);
    push_g(1'b0, 32'h040, '0, 4'hF, 1'b0);
    push_r(1'b1, model_rdata(32'h300), 1'b0, 1);
    push_r(1'b0, model_rdata(32'h040), 1'b0, 1);
    fork
      data(1'b0, 32'h300, '0, 4'hF);
      fetch(32'h040);
    join

    // Starvation guard: D,D,D,D,I repeating
    for (int i = 0; i < 8; i++) begin
      push_g(1'b0, 32'h400 + 32'(i * 4), '0, 4'hF, 1'b0);
      push_r(1'b1, model_rdata(32'h400 + 32'(i * 4)), 1'b0, 1);
      if (i == 3 || i == 7) begin
        push_g(1'b0, (i == 3) ? 32'h44 : 32'h48, '0, 4'hF, 1'b0);
        push_r(1'b0, model_rdata((i == 3) ? 32'h44 : 32'h48), 1'b0, 1);
      end
    end
    fork
      for (int i = 0; i < 8; i++) data(1'b0, 32'h400 + 32'(i * 4), '0, 4'hF);
      begin
        fetch(32'h44);
        fetch(32'h48);
      end
    join

    // Timeout with no ack
    lat = -1;
    push_g(1'b0, 32'h500, '0, 4'hF, 1'b0);
    push_r(1'b1, 32'd0, 1'b1, TOUT);
    data(1'b0, 32'h500, '0, 4'hF);

    // Ack on the timeout cycle wins
    lat = TOUT - 1;
    push_g(1'b0, 32'h504, '0, 4'hF, 1'b0);
    push_r(1'b1, model_rdata(32'h504), 1'b0, TOUT);
    data(1'b0, 32'h504, '0, 4'hF);

    // Reset in busy cycle 2 of a 5-cycle fetch
    lat = 4;
    push_g(1'b0, 32'h80, '0, 4'hF, 1'b0);
    if_req = 1'b1; if_addr = 32'h80;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    check("rst_abort_mem_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(negedge clk);
    check("stray_ack_no_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    check("stray_ack_no_req",   {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    stray_ack = 1'b0;

    // Normal service after reset
    lat = 1;
    push_g(1'b0, 32'h84, '0, 4'hF, 1'b0);
    push_r(1'b0, model_rdata(32'h84), 1'b0, 2);
    fetch(32'h84);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", resp_q.size() + grant_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
